// File: rtl/comparador_pkg.sv
// Shared definitions for the serial slice comparator: default geometry and FSM encoding.
package comparador_pkg;

   localparam int SLICE_W_DEF  = 3;
   localparam int N_SLICES_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      FIN  = 2'd2
   } state_e;

endpackage

// File: rtl/cmp_slice.sv
// Combinational equality of one operand slice.
module cmp_slice #(
   parameter int SLICE_W = comparador_pkg::SLICE_W_DEF
) (
   input  logic [SLICE_W-1:0] x,
   input  logic [SLICE_W-1:0] y,
   output logic               eq
);

   assign eq = &(x ~^ y);

endmodule

// File: rtl/comparador_serial_ctrl.sv
// Serial comparator: walks latched operands one slice per cycle, LSB first,
// stopping at the first mismatching slice.
module comparador_serial_ctrl
   import comparador_pkg::*;
#(
   parameter int SLICE_W  = SLICE_W_DEF,
   parameter int N_SLICES = N_SLICES_DEF
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [SLICE_W*N_SLICES-1:0]     a,
   input  logic [SLICE_W*N_SLICES-1:0]     b,
   input  logic                            select,
   output logic                            busy,
   output logic                            done,
   output logic                            s_out,
   output logic [$clog2(N_SLICES+1)-1:0]   slices_used
);

   localparam int IDX_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
   localparam int CNT_W = $clog2(N_SLICES+1);

   state_e                            state_q, state_d;
   logic [IDX_W-1:0]                  idx_q, idx_d;
   logic [N_SLICES-1:0][SLICE_W-1:0]  a_q, a_d, b_q, b_d;
   logic                              sel_q, sel_d;
   logic                              s_out_q, s_out_d;
   logic [CNT_W-1:0]                  used_q, used_d;
   logic                              slice_eq;

   // Single comparator shared across all slices; the index selects which pair it sees.
   cmp_slice #(.SLICE_W(SLICE_W)) u_cmp_slice (
      .x  (a_q[idx_q]),
      .y  (b_q[idx_q]),
      .eq (slice_eq)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      sel_d   = sel_q;
      s_out_d = s_out_q;
      used_d  = used_q;
      case (state_q)
         IDLE, FIN: begin
            if (start) begin
               state_d = CMP;
               idx_d   = '0;
               a_d     = a;
               b_d     = b;
               sel_d   = select;
            end else begin
               state_d = IDLE;
            end
         end
         CMP: begin
            if (!slice_eq) begin
               state_d = FIN;
               s_out_d = sel_q;
               used_d  = CNT_W'(idx_q) + CNT_W'(1);
            end else if (idx_q == IDX_W'(N_SLICES-1)) begin
               state_d = FIN;
               s_out_d = ~sel_q;
               used_d  = CNT_W'(N_SLICES);
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= 1'b0;
         s_out_q <= 1'b0;
         used_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sel_q   <= sel_d;
         s_out_q <= s_out_d;
         used_q  <= used_d;
      end
   end

   assign busy        = (state_q == CMP);
   assign done        = (state_q == FIN);
   assign s_out       = s_out_q;
   assign slices_used = used_q;

endmodule

// File: tb/tb_comparador_serial_ctrl.sv
// Self-checking bench for comparador_serial_ctrl against a slice-scan reference model.
module tb_comparador_serial_ctrl;

   localparam int SW = 3;
   localparam int NS = 4;
   localparam int W  = SW*NS;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [W-1:0]  a, b;
   logic          select;
   logic          busy, done, s_out;
   logic [2:0]    slices_used;

   int checks   = 0;
   int failures = 0;

   comparador_serial_ctrl #(.SLICE_W(SW), .N_SLICES(NS)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .a           (a),
      .b           (b),
      .select      (select),
      .busy        (busy),
      .done        (done),
      .s_out       (s_out),
      .slices_used (slices_used)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: first differing slice ends the scan; result is equality XOR mode.
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic ms, output logic o_s, output int o_used);
      logic eq;
      logic [W-1:0] diff;
      eq     = 1'b1;
      o_used = NS;
      diff   = ma ^ mb;
      for (int i = 0; i < NS; i++) begin
         if (((diff >> (i*SW)) & W'((1 << SW) - 1)) != 0) begin
            eq     = 1'b0;
            o_used = i + 1;
            break;
         end
      end
      o_s = eq ^ ms;
   endfunction

   // Waits (bounded) for done, counting edges since the start edge and busy cycles.
   task automatic wait_done(input string tag, input int lat0, output int lat, output int bcnt);
      lat  = lat0;
      bcnt = 0;
      while (!done && lat < 20) begin
         if (busy) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_done"}, done, 1'b1);
   endtask

   task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic ts, input bit scramble);
      logic es;
      int   eu, lat, bcnt;
      model(ta, tb_, ts, es, eu);
      @(negedge clk);
      a = ta; b = tb_; select = ts; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (scramble) begin
         a = W'($urandom); b = W'($urandom); select = 1'($urandom);
      end
      wait_done(tag, 1, lat, bcnt);
      check({tag, "_lat"},   lat, eu + 1);
      check({tag, "_busy"},  bcnt, eu);
      check({tag, "_s"},     s_out, es);
      check({tag, "_used"},  slices_used, eu);
      @(posedge clk); #1;
      check({tag, "_pulse"}, {busy, done}, 2'b00);
      check({tag, "_hold"},  {s_out, slices_used}, {es, 3'(eu)});
   endtask

   initial begin
      logic es1, es2;
      int   eu1, eu2, lat, bcnt, dcnt;
      logic [W-1:0] ra, rb;

      reset = 1'b1; start = 1'b0; a = '0; b = '0; select = 1'b0;
      #12;
      check("rst_out", {busy, done, s_out, slices_used}, 6'b0);
      @(negedge clk); reset = 1'b0;

      do_op("eq_all",   12'hA5A, 12'hA5A, 1'b0, 1'b0);
      do_op("mis_s0",   12'hA5A, 12'hA5B, 1'b0, 1'b0);
      do_op("mis_s3",   12'h123, 12'h923, 1'b1, 1'b0);
      // Late change of b must not leak into the latched operand.
      @(negedge clk);
      a = 12'h123; b = 12'h923; select = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; b = 12'h123;
      wait_done("late_b", 1, lat, bcnt);
      check("late_b_lat",  lat, 5);
      check("late_b_s",    s_out, 1'b1);
      check("late_b_used", slices_used, 4);

      // Back-to-back: start held high through CMP and FIN.
      model(12'h3C7, 12'h3C7, 1'b1, es1, eu1);
      model(12'h456, 12'h476, 1'b0, es2, eu2);
      @(negedge clk);
      a = 12'h3C7; b = 12'h3C7; select = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      a = 12'h456; b = 12'h476; select = 1'b0;
      wait_done("b2b1", 1, lat, bcnt);
      check("b2b1_lat",  lat, eu1 + 1);
      check("b2b1_s",    s_out, es1);
      check("b2b1_used", slices_used, eu1);
      @(posedge clk); #1;
      check("b2b_noidle", {busy, done}, 2'b10);
      start = 1'b0;
      wait_done("b2b2", 1, lat, bcnt);
      check("b2b2_lat",  lat, eu2 + 1);
      check("b2b2_s",    s_out, es2);
      check("b2b2_used", slices_used, eu2);
      @(posedge clk); #1;

      // Start pulses mid-CMP are ignored.
      @(negedge clk);
      a = 12'hFFF; b = 12'hFFF; select = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0; a = 12'h000;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      #1;
      wait_done("ign", 3, lat, bcnt);
      check("ign_lat",  lat, 5);
      check("ign_s",    s_out, 1'b1);
      check("ign_used", slices_used, 4);
      @(posedge clk); #1;

      // Reset during CMP at idx=2.
      @(negedge clk);
      a = 12'h555; b = 12'h555; select = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      check("pre_rst_busy", busy, 1'b1);
      reset = 1'b1; #1;
      check("rst_mid", {busy, done, s_out, slices_used}, 6'b0);
      dcnt = 0;
      repeat (3) begin @(posedge clk); #1; if (done) dcnt++; end
      @(negedge clk); reset = 1'b0;
      repeat (5) begin @(posedge clk); #1; if (done) dcnt++; end
      check("rst_nodone", dcnt, 0);
      do_op("post_rst", 12'h777, 12'h7F7, 1'b0, 1'b0);

      // Randomized sweep biased toward every mismatch position.
      for (int n = 0; n < 30; n++) begin
         int k;
         ra = W'($urandom);
         k  = $urandom_range(0, NS);
         if (k == NS) rb = ra;
         else         rb = ra ^ (W'($urandom_range(1, 7)) << (k*SW)) ^ (W'($urandom) & ~W'((1 << ((k+1)*SW)) - 1));
         do_op($sformatf("rnd%0d", n), ra, rb, 1'($urandom), bit'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/comparador_serial_ctrl.md
COMPARADOR_SERIAL_CTRL -- requirements
Module: comparador_serial_ctrl

Interface
REQ-001 The block SHALL have parameter SLICE_W, default 3, giving the bits compared per cycle.
REQ-002 The block SHALL have parameter N_SLICES, default 4, giving the slices per operand; operand width W = SLICE_W*N_SLICES (12).
REQ-003 The block SHALL have port clk, input, 1 bit, single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit, request to begin a comparison.
REQ-006 The block SHALL have port a, input, W bits, first operand.
REQ-007 The block SHALL have port b, input, W bits, second operand.
REQ-008 The block SHALL have port select, input, 1 bit, mode: 0 = equality, 1 = difference.
REQ-009 The block SHALL have port busy, output, 1 bit, high while a comparison is in progress.
REQ-010 The block SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-011 The block SHALL have port s_out, output, 1 bit, registered result, valid from the done pulse onward.
REQ-012 The block SHALL have port slices_used, output, clog2(N_SLICES+1) bits (3), number of slices compared in the last operation.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CMP and FIN.
REQ-014 In IDLE or FIN, start=1 at a rising edge SHALL latch a, b and select, clear the slice index to 0, and enter CMP.
REQ-015 start SHALL be ignored while in CMP; the latched operands and mode SHALL remain unchanged.
REQ-016 Each CMP cycle SHALL compare latched slice [idx*SLICE_W +: SLICE_W] of a against b, LSB slice first, with one slice per cycle.
REQ-017 A slice mismatch SHALL end the operation early: next state FIN, eq=0, slices_used=idx+1.
REQ-018 A match on idx = N_SLICES-1 SHALL give next state FIN, eq=1, slices_used=N_SLICES.
REQ-019 A match on idx < N_SLICES-1 SHALL increment idx and remain in CMP.
REQ-020 On entry to FIN, s_out SHALL be registered as eq XOR latched select.
REQ-021 s_out and slices_used SHALL hold their values until the next FIN entry or reset.
REQ-022 busy SHALL be 1 exactly when the state is CMP.
REQ-023 done SHALL be 1 exactly when the state is FIN, for one cycle.
REQ-024 FIN SHALL go to IDLE when start=0, or to CMP under REQ-014 when start=1, giving back-to-back operations.
REQ-025 Latency from the start edge to done high SHALL be k+1 cycles, where k = slices_used (all-equal case: 5 cycles).
REQ-026 Input changes on a, b or select after the start edge SHALL NOT affect the result.

Reset
REQ-027 Asserting reset SHALL immediately force: state IDLE, idx 0, busy 0, done 0, s_out 0, slices_used 0, operand registers 0.
REQ-028 Reset mid-CMP SHALL discard the operation with no done pulse.
REQ-029 Operation SHALL resume on the first rising edge with reset low and start high.

Structure
REQ-030 The state encoding (IDLE=2'd0, CMP=2'd1, FIN=2'd2) and the default SLICE_W/N_SLICES values SHALL live in a shared package comparador_pkg.
REQ-031 The per-slice compare SHALL be one combinational sub-module cmp_slice (inputs SLICE_W-bit x, y; output eq = AND of bitwise XNOR).
REQ-032 cmp_slice SHALL be instantiated once and fed by an index-driven mux; it SHALL NOT be replicated N_SLICES times.
REQ-033 All state SHALL live in one sequential process with asynchronous reset; next-state and output decode SHALL be combinational.

Verification
REQ-034 Bench SHALL cover: a=b=12'hA5A, select=0, one-cycle start -> busy for 4 cycles, done on cycle 5, s_out=1, slices_used=4.
REQ-035 Bench SHALL cover: a=12'hA5A, b=12'hA5B, select=0 -> mismatch in slice 0, done on cycle 2, s_out=0, slices_used=1.
REQ-036 Bench SHALL cover: a=12'h123, b=12'h923, select=1 -> mismatch in slice 3, done on cycle 5, s_out=1, slices_used=4; a repeat with b driven to 12'h123 after the start edge gives the identical result.
REQ-037 Bench SHALL cover: start held high across FIN with a new operand pair -> second operation starts with no IDLE cycle, and start pulses issued during CMP are ignored.
REQ-038 Bench SHALL cover: reset pulsed during CMP idx=2 -> all outputs 0 asynchronously, no done pulse, and a following start completes normally.
